// File: rtl/smg_pkg.sv
// Shared constants for the seven-segment page arbiter.
package smg_pkg;

    localparam int unsigned NUM_W  = 24;
    localparam int unsigned PAGE_W = 2;

    localparam int unsigned DEF_HOLD_CYCLES = 25_000_000;
    localparam int unsigned DEF_IDLE_CYCLES = 150_000_000;

    localparam logic [PAGE_W-1:0] PAGE_HOME = 2'd0;
    localparam logic [PAGE_W-1:0] PAGE_S1   = 2'd1;
    localparam logic [PAGE_W-1:0] PAGE_S2   = 2'd2;

    // Counter width able to hold the given terminal value.
    function automatic int unsigned cnt_width(input int unsigned terminal);
        return $clog2(terminal) + 1;
    endfunction

endpackage

// File: rtl/smg_timer.sv
// Clearable saturating up-counter with a terminal-count flag.
module smg_timer
    import smg_pkg::*;
#(
    parameter int unsigned TERMINAL = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tc_c
);

    localparam int unsigned          CNT_W  = cnt_width(TERMINAL);
    localparam logic [CNT_W-1:0]     CNT_TC = CNT_W'(TERMINAL);

    logic [CNT_W-1:0] cnt_q;

    assign tc_c = (cnt_q == CNT_TC);

    // Count up from zero after a clear and stick at the terminal value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (!tc_c) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/smg_page_arbiter.sv
// Shares the six-digit display between a home page and two transient pages,
// enforcing a minimum hold time and an idle release timeout.
module smg_page_arbiter
    import smg_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int unsigned IDLE_CYCLES = DEF_IDLE_CYCLES
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic [NUM_W-1:0]  Num0_Sig,
    input  logic [NUM_W-1:0]  Num1_Sig,
    input  logic [NUM_W-1:0]  Num2_Sig,
    input  logic [2:0]        Upd_Sig,
    output logic [NUM_W-1:0]  Number_Sig,
    output logic [PAGE_W-1:0] Page_Sig
);

    localparam logic [1:0] ST_HOME  = PAGE_HOME;
    localparam logic [1:0] ST_SHOW1 = PAGE_S1;
    localparam logic [1:0] ST_SHOW2 = PAGE_S2;

    if (IDLE_CYCLES <= HOLD_CYCLES) begin : g_param_check
        $error("smg_page_arbiter: IDLE_CYCLES must be greater than HOLD_CYCLES");
    end

    logic [1:0]       state_q, state_d;
    logic [2:1]       pend_q, pend_d;
    logic             defer_q, defer_d;
    logic             hold_tc_c, idle_tc_c;
    logic             hold_clr_c, idle_clr_c;
    logic             own_upd_c, oth_upd_c;
    logic [1:0]       oth_page_c;
    logic [NUM_W-1:0] data_c;
    logic             unused_upd0;

    // Home source has no update strobe of interest.
    assign unused_upd0 = Upd_Sig[0];

    // Hold timer: expired HOLD_CYCLES edges after the grant.
    smg_timer #(.TERMINAL(HOLD_CYCLES)) u_hold (
        .clk   (CLK),
        .rst_n (RSTn),
        .clr   (hold_clr_c),
        .tc_c  (hold_tc_c)
    );

    // Idle timer: flags in the cycle before the release edge.
    smg_timer #(.TERMINAL(IDLE_CYCLES - 1)) u_idle (
        .clk   (CLK),
        .rst_n (RSTn),
        .clr   (idle_clr_c),
        .tc_c  (idle_tc_c)
    );

    // Next page, pending requests and timer restarts.
    // A pre-emption deferred during hold is serviced at hold expiry; a pending
    // bit left by simultaneous home requests waits for the idle release.
    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        defer_d    = defer_q;
        hold_clr_c = 1'b0;
        idle_clr_c = 1'b0;
        own_upd_c  = 1'b0;
        oth_upd_c  = 1'b0;
        oth_page_c = ST_HOME;

        case (state_q)
            ST_SHOW1: begin
                own_upd_c  = Upd_Sig[1];
                oth_upd_c  = Upd_Sig[2];
                oth_page_c = ST_SHOW2;
            end
            ST_SHOW2: begin
                own_upd_c  = Upd_Sig[2];
                oth_upd_c  = Upd_Sig[1];
                oth_page_c = ST_SHOW1;
            end
            default: ;
        endcase

        if (state_q == ST_SHOW1 || state_q == ST_SHOW2) begin
            if (own_upd_c) begin
                idle_clr_c = 1'b1;
            end
            if (hold_tc_c && (oth_upd_c || defer_q)) begin
                state_d = oth_page_c;
            end else if (oth_upd_c) begin
                defer_d = 1'b1;
                if (oth_page_c == ST_SHOW2) begin
                    pend_d[2] = 1'b1;
                end else begin
                    pend_d[1] = 1'b1;
                end
            end else if (idle_tc_c && !own_upd_c) begin
                if (pend_q[2]) begin
                    state_d = ST_SHOW2;
                end else if (pend_q[1]) begin
                    state_d = ST_SHOW1;
                end else begin
                    state_d = ST_HOME;
                end
            end
        end else begin
            state_d = ST_HOME;
            if (Upd_Sig[2]) begin
                state_d   = ST_SHOW2;
                pend_d[1] = pend_q[1] | Upd_Sig[1];
            end else if (Upd_Sig[1]) begin
                state_d = ST_SHOW1;
            end
        end

        if (state_d != state_q && state_d != ST_HOME) begin
            hold_clr_c = 1'b1;
            idle_clr_c = 1'b1;
            defer_d    = 1'b0;
            if (state_d == ST_SHOW2) begin
                pend_d[2] = 1'b0;
            end else begin
                pend_d[1] = 1'b0;
            end
        end
    end

    // Source data of the page that will be shown after this edge.
    always_comb begin
        data_c = Num0_Sig;
        case (state_d)
            ST_SHOW1: data_c = Num1_Sig;
            ST_SHOW2: data_c = Num2_Sig;
            default:  ;
        endcase
    end

    // State, pending requests and display word registers.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= ST_HOME;
            pend_q     <= '0;
            defer_q    <= 1'b0;
            Number_Sig <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            defer_q    <= defer_d;
            Number_Sig <= data_c;
        end
    end

    assign Page_Sig = state_q;

endmodule

// File: tb/tb_smg_page_arbiter.sv
// Directed bench for smg_page_arbiter with HOLD_CYCLES=4, IDLE_CYCLES=10.
module tb_smg_page_arbiter;

    logic        CLK;
    logic        RSTn;
    logic [23:0] n0, n1, n2;
    logic [2:0]  upd;
    logic [23:0] Number_Sig;
    logic [1:0]  Page_Sig;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [2:0]  upd;
        logic [23:0] n0;
        logic [23:0] n1;
        logic [23:0] n2;
        logic [1:0]  page;
        logic [23:0] num;
    } vec_t;

    vec_t vecs [16];

    smg_page_arbiter #(.HOLD_CYCLES(4), .IDLE_CYCLES(10)) dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .Num0_Sig   (n0),
        .Num1_Sig   (n1),
        .Num2_Sig   (n2),
        .Upd_Sig    (upd),
        .Number_Sig (Number_Sig),
        .Page_Sig   (Page_Sig)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic expect_page(input string name, input logic [1:0] page);
        check(name, {22'd0, Page_Sig}, {22'd0, page});
    endtask

    initial begin
        RSTn = 1'b0;
        upd  = 3'b000;
        n0   = 24'h000100;
        n1   = 24'h123456;
        n2   = 24'habcdef;

        //          upd     n0          n1          n2          page  num
        vecs[0]  = '{3'b010, 24'h000100, 24'h123456, 24'habcdef, 2'd1, 24'h123456};
        vecs[1]  = '{3'b100, 24'h000100, 24'h123456, 24'habcdef, 2'd1, 24'h123456};
        vecs[2]  = '{3'b000, 24'h000100, 24'h000999, 24'habcdef, 2'd1, 24'h000999};
        vecs[3]  = '{3'b000, 24'h000777, 24'h000999, 24'habcdef, 2'd1, 24'h000999};
        vecs[4]  = '{3'b000, 24'h000777, 24'h000999, 24'habcdef, 2'd1, 24'h000999};
        vecs[5]  = '{3'b000, 24'h000777, 24'h000999, 24'habcdef, 2'd2, 24'habcdef};
        vecs[6]  = '{3'b000, 24'h000777, 24'h000999, 24'h0000aa, 2'd2, 24'h0000aa};
        vecs[7]  = '{3'b010, 24'h000777, 24'h000999, 24'h0000aa, 2'd2, 24'h0000aa};
        vecs[8]  = '{3'b000, 24'h000777, 24'h000999, 24'h0000aa, 2'd2, 24'h0000aa};
        vecs[9]  = '{3'b000, 24'h000777, 24'h000999, 24'h0000aa, 2'd2, 24'h0000aa};
        vecs[10] = '{3'b000, 24'h000777, 24'h000999, 24'h0000aa, 2'd1, 24'h000999};
        vecs[11] = '{3'b000, 24'h000777, 24'h000999, 24'h0000aa, 2'd1, 24'h000999};
        vecs[12] = '{3'b000, 24'h000777, 24'h000999, 24'h0000aa, 2'd1, 24'h000999};
        vecs[13] = '{3'b000, 24'h000777, 24'h000999, 24'h0000aa, 2'd1, 24'h000999};
        vecs[14] = '{3'b000, 24'h000777, 24'h000999, 24'h0000aa, 2'd1, 24'h000999};
        vecs[15] = '{3'b100, 24'h000777, 24'h000999, 24'h0000aa, 2'd2, 24'h0000aa};

        // Reset state, then the first edge after release loads the home page.
        repeat (2) @(posedge CLK);
        #1;
        expect_page("reset_page", 2'd0);
        check("reset_num", Number_Sig, 24'h000000);
        RSTn = 1'b1;
        tick();
        expect_page("release_page", 2'd0);
        check("release_num", Number_Sig, 24'h000100);

        // Grant, deferred pre-emption, live tracking, expiry-edge pre-emption.
        for (int i = 0; i < 16; i++) begin
            upd = vecs[i].upd;
            n0  = vecs[i].n0;
            n1  = vecs[i].n1;
            n2  = vecs[i].n2;
            tick();
            expect_page($sformatf("vec%0d_page", i), vecs[i].page);
            check($sformatf("vec%0d_num", i), Number_Sig, vecs[i].num);
        end
        upd = 3'b000;

        // Idle release from page 2 back to home.
        for (int c = 1; c <= 9; c++) begin
            tick();
            expect_page($sformatf("idle2_c%0d", c), 2'd2);
        end
        tick();
        expect_page("idle2_release", 2'd0);
        check("idle2_num", Number_Sig, 24'h000777);

        // Grant from home and timeout ten edges after the grant.
        n1  = 24'h123456;
        upd = 3'b010;
        tick();
        upd = 3'b000;
        expect_page("grant1_page", 2'd1);
        check("grant1_num", Number_Sig, 24'h123456);
        for (int c = 1; c <= 9; c++) begin
            tick();
            expect_page($sformatf("grant1_c%0d", c), 2'd1);
        end
        tick();
        expect_page("grant1_release", 2'd0);

        // Simultaneous requests: page 2, then pending page 1, then home.
        upd = 3'b110;
        tick();
        upd = 3'b000;
        expect_page("simul_page", 2'd2);
        check("simul_num", Number_Sig, 24'h0000aa);
        for (int c = 1; c <= 9; c++) begin
            tick();
            expect_page($sformatf("simul2_c%0d", c), 2'd2);
        end
        tick();
        expect_page("simul_to1", 2'd1);
        check("simul_to1_num", Number_Sig, 24'h123456);
        for (int c = 1; c <= 9; c++) begin
            tick();
            expect_page($sformatf("simul1_c%0d", c), 2'd1);
        end
        tick();
        expect_page("simul_home", 2'd0);

        // Keep-alive pulses every 8 cycles hold page 1.
        upd = 3'b010;
        tick();
        upd = 3'b000;
        expect_page("keep_grant", 2'd1);
        for (int c = 1; c <= 40; c++) begin
            if (c % 8 == 0) upd = 3'b010;
            tick();
            upd = 3'b000;
            expect_page($sformatf("keep_c%0d", c), 2'd1);
        end
        for (int c = 1; c <= 9; c++) begin
            tick();
            expect_page($sformatf("keep_tail%0d", c), 2'd1);
        end
        tick();
        expect_page("keep_release", 2'd0);

        // Asynchronous reset while page 2 is shown.
        upd = 3'b100;
        tick();
        upd = 3'b000;
        expect_page("prerst_page", 2'd2);
        #3 RSTn = 1'b0;
        #1;
        expect_page("async_rst_page", 2'd0);
        check("async_rst_num", Number_Sig, 24'h000000);
        tick();
        check("held_rst_num", Number_Sig, 24'h000000);
        n0   = 24'h000100;
        RSTn = 1'b1;
        tick();
        expect_page("rerelease_page", 2'd0);
        check("rerelease_num", Number_Sig, 24'h000100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
